// File: rtl/alu_pkg.sv
// Shared constants for the ALU issuer: mode-op codes, FSM state encoding, flag bit positions.
package alu_pkg;

  localparam logic [7:0] CLR_CMP  = 8'h40;
  localparam logic [7:0] CMP_OFF  = 8'h41;
  localparam logic [7:0] CMP_ON   = 8'h42;
  localparam logic [7:0] SIGN_OFF = 8'h43;
  localparam logic [7:0] SIGN_ON  = 8'h44;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT0   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_t;

  // Flags are packed {N, Z, V, C}.
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  function automatic logic is_mode_op(input logic [7:0] op);
    return (op >= CLR_CMP) && (op <= SIGN_ON);
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Sticky {N,Z,V,C} flag register, loaded from the ALU result when upd is high; 1-cycle update, no backpressure.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [7:0] res,
  input  logic       carry,
  input  logic       over,
  output logic [3:0] flags
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (upd) begin
      flags[FLAG_C] <= carry;
      flags[FLAG_V] <= over;
      flags[FLAG_Z] <= (res == 8'h00);
      flags[FLAG_N] <= res[7];
    end
  end

endmodule

// File: rtl/alu_issuer.sv
// Single-outstanding ALU sequencer: 5-cycle min compute latency, 2-cycle mode ops; response held until rsp_ready.
// Define ALU_ISSUE_TIMEOUT_EN to add an 8-bit WAIT watchdog that answers with rsp_err after 255 cycles.
module alu_issuer
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] flags,
  output logic       alu_start,
  input  logic       alu_done,
  output logic [7:0] alu_cins,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_oe,
  output logic       alu_carryin,
  input  logic [7:0] alu_out,
  input  logic       alu_carryout,
  input  logic       alu_overout,
  input  logic       alu_cmpo
);

  state_t     state, state_nxt;
  logic [7:0] op_q, a_q, b_q, data_q;
  logic       mode_q;
  logic       accept;
  logic       active;
  logic       unused_cmpo;

  assign unused_cmpo = alu_cmpo;

  assign accept = req_valid && req_ready;
  assign active = (state != ST_IDLE);

`ifdef ALU_ISSUE_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + 8'd1 : 8'd0;
      if (accept)
        err_q <= 1'b0;
      else if (state == ST_TIMEOUT)
        err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == ST_RESP) ? err_q : 1'b0;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = mode_q ? ST_RESP : ST_WAIT0;
      // The ALU only drops done one cycle after start, so done is not trusted here.
      ST_WAIT0:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (alu_done)
          state_nxt = ST_CAPTURE;
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (wd_cnt == 8'd254)
          state_nxt = ST_TIMEOUT;
`endif
      end
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_TIMEOUT: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 8'h00;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      data_q <= 8'h00;
      mode_q <= 1'b0;
    end else if (accept) begin
      op_q   <= req_op;
      a_q    <= req_a;
      b_q    <= req_b;
      data_q <= 8'h00;
      mode_q <= is_mode_op(req_op);
    end else if (state == ST_CAPTURE) begin
      data_q <= alu_out;
    end
  end

  alu_flag_reg u_flag_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .upd   (state == ST_CAPTURE),
    .res   (alu_out),
    .carry (alu_carryout),
    .over  (alu_overout),
    .flags (flags)
  );

  // rst_n gates req_ready so nothing is offered while reset is held.
  assign req_ready   = rst_n && (state == ST_IDLE) && alu_done;
  assign alu_start   = (state == ST_ISSUE) && !mode_q;
  // Mode ops present their code for the ISSUE cycle only.
  assign alu_cins    = ((state == ST_ISSUE) || (active && !mode_q)) ? op_q : 8'h00;
  assign alu_a       = active ? a_q : 8'h00;
  assign alu_b       = active ? b_q : 8'h00;
  assign alu_oe      = (state == ST_CAPTURE);
  assign alu_carryin = flags[FLAG_C];
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_data    = rsp_valid ? data_q : 8'h00;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a small behavioural ALU (op 0x01 = ADD with carry, 0x03 = AND).
module tb_alu_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_op = 8'h00, req_a = 8'h00, req_b = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] flags;
  logic       alu_start, alu_oe, alu_carryin;
  logic [7:0] alu_cins, alu_a, alu_b;

  logic       m_done, m_post, m_busy, m_c, m_v;
  logic       m_stuck = 1'b0;
  logic [7:0] m_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .flags(flags),
    .alu_start(alu_start), .alu_done(m_done), .alu_cins(alu_cins),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oe(alu_oe), .alu_carryin(alu_carryin),
    .alu_out(m_res), .alu_carryout(m_c), .alu_overout(m_v), .alu_cmpo(1'b0)
  );

  function automatic logic [9:0] alu_calc(input logic [7:0] op, a, b, input logic cin);
    logic [8:0] sum;
    logic       v;
    if (op == 8'h01) begin
      sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      v   = (a[7] == b[7]) && (sum[7] != a[7]);
      return {v, sum};
    end
    return {2'b00, a & b};
  endfunction

  // ALU model: done low for one cycle after reset, low for one cycle after start.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_post <= 1'b1; m_busy <= 1'b0;
      m_res <= 8'h00; m_c <= 1'b0; m_v <= 1'b0;
    end else if (m_stuck) begin
      m_done <= 1'b0;
    end else if (m_post) begin
      m_post <= 1'b0;
    end else if (alu_start) begin
      m_done <= 1'b0;
      m_busy <= 1'b1;
      {m_v, m_c, m_res} <= alu_calc(alu_cins, alu_a, alu_b, alu_carryin);
    end else begin
      m_busy <= 1'b0;
      m_done <= 1'b1;
    end
  end

  // lat counts cycles from the accept cycle (=0) to the first cycle with rsp_valid.
  task automatic issue(input logic [7:0] op, a, b, output int lat, output int starts, output int cins_cyc);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 8'h00; req_a = 8'h00; req_b = 8'h00;
    lat = 1; starts = 0; cins_cyc = 0;
    while (!rsp_valid && lat < 400) begin
      if (alu_start) starts++;
      if (alu_cins == op) cins_cyc++;
      @(negedge clk);
      lat++;
    end
    if (alu_start) starts++;
    if (alu_cins == op) cins_cyc++;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, flags, alu_start, alu_cins, alu_a, alu_b, alu_oe, alu_carryin} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero during reset, rsp_data=%h flags=%b req_ready=%b required all 0", rsp_data, flags, req_ready);
    end
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL ready_at_release: got %b required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL ready_done_low: got %b required 0", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_done: got %b required 1", req_ready); end
  endtask

  task automatic test_add_carry();
    int lat, st, cc;
    issue(8'h01, 8'hFF, 8'h01, lat, st, cc);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL add_latency: got %0d required 5", lat); end
    checks++;
    if (st !== 1) begin failures++; $display("FAIL add_start_pulses: got %0d required 1", st); end
    checks++;
    if (rsp_data !== 8'h00) begin failures++; $display("FAIL add_data: got %h required 00", rsp_data); end
    checks++;
    if (flags !== 4'b0101) begin failures++; $display("FAIL add_flags: got %b required 0101", flags); end
    take_rsp();
    checks++;
    if (alu_carryin !== 1'b1) begin failures++; $display("FAIL carryin_after_add: got %b required 1", alu_carryin); end
  endtask

  task automatic test_mode();
    int lat, st, cc;
    issue(8'h42, 8'h33, 8'h44, lat, st, cc);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL mode_latency: got %0d required 2", lat); end
    checks++;
    if (st !== 0) begin failures++; $display("FAIL mode_start: got %0d pulses required 0", st); end
    checks++;
    if (cc !== 1) begin failures++; $display("FAIL mode_cins_cycles: got %0d required 1", cc); end
    checks++;
    if (rsp_data !== 8'h00 || flags !== 4'b0101) begin
      failures++;
      $display("FAIL mode_result: data=%h flags=%b required data=00 flags=0101", rsp_data, flags);
    end
    take_rsp();
  endtask

  task automatic test_chain();
    int lat, st, cc;
    checks++;
    if (alu_carryin !== 1'b1) begin failures++; $display("FAIL chain_carryin: got %b required 1", alu_carryin); end
    issue(8'h01, 8'h00, 8'h00, lat, st, cc);
    checks++;
    if (rsp_data !== 8'h01 || flags !== 4'b0000) begin
      failures++;
      $display("FAIL chain_result: data=%h flags=%b required data=01 flags=0000", rsp_data, flags);
    end
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int lat, st, cc, guard;
    issue(8'h01, 8'h70, 8'h10, lat, st, cc);
    checks++;
    if (rsp_data !== 8'h80 || flags !== 4'b1010) begin
      failures++;
      $display("FAIL ovf_result: data=%h flags=%b required data=80 flags=1010", rsp_data, flags);
    end
    req_valid = 1'b1; req_op = 8'h03; req_a = 8'h0F; req_b = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h80 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid=%b data=%h req_ready=%b required 1/80/0", i, rsp_valid, rsp_data, req_ready);
      end
    end
    take_rsp();
    checks++;
    if (alu_cins !== 8'h00 || alu_start !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_accept: cins=%h start=%b required 00/0", alu_cins, alu_start);
    end
    @(negedge clk);
    checks++;
    if (alu_cins !== 8'h03 || alu_start !== 1'b1) begin
      failures++;
      $display("FAIL next_issue: cins=%h start=%b required 03/1", alu_cins, alu_start);
    end
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h0C || flags !== 4'b0000) begin
      failures++;
      $display("FAIL and_result: valid=%b data=%h flags=%b required 1/0C/0000", rsp_valid, rsp_data, flags);
    end
    take_rsp();
  endtask

  task automatic test_timeout();
    int lat, st, cc, guard;
    issue(8'h01, 8'h80, 8'h80, lat, st, cc);
    checks++;
    if (flags !== 4'b0111) begin failures++; $display("FAIL pre_timeout_flags: got %b required 0111", flags); end
    take_rsp();
    @(negedge clk);
    req_valid = 1'b1; req_op = 8'h01; req_a = 8'h12; req_b = 8'h34;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    m_stuck = 1'b1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
`ifdef ALU_ISSUE_TIMEOUT_EN
    checks++;
    if (lat !== 259) begin failures++; $display("FAIL timeout_latency: got %0d required 259", lat); end
    checks++;
    if (rsp_err !== 1'b1 || rsp_data !== 8'h00 || flags !== 4'b0111) begin
      failures++;
      $display("FAIL timeout_rsp: err=%b data=%h flags=%b required 1/00/0111", rsp_err, rsp_data, flags);
    end
    m_stuck = 1'b0;
    take_rsp();
`else
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_exit: valid=%b err=%b required 0/0", rsp_valid, rsp_err);
    end
    m_stuck = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    take_rsp();
`endif
  endtask

  task automatic test_reset_in_wait();
    int guard, stale;
    @(negedge clk);
    req_valid = 1'b1; req_op = 8'h01; req_a = 8'h05; req_b = 8'h06;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    m_stuck = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (alu_cins !== 8'h01 || alu_a !== 8'h05 || rsp_valid !== 1'b0 || alu_oe !== 1'b0) begin
      failures++;
      $display("FAIL in_wait: cins=%h a=%h valid=%b oe=%b required 01/05/0/0", alu_cins, alu_a, rsp_valid, alu_oe);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, flags, alu_start, alu_cins, alu_a, alu_b, alu_oe, alu_carryin} !== '0) begin
      failures++;
      $display("FAIL midop_reset: cins=%h a=%h valid=%b flags=%b required all 0", alu_cins, alu_a, rsp_valid, flags);
    end
    m_stuck = 1'b0;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_cins != 8'h00) stale++;
    end
    checks++;
    if (stale !== 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_idle: stale_cycles=%0d req_ready=%b required 0/1", stale, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_mode();
    test_chain();
    test_back_to_back();
    test_timeout();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
